// File: rtl/uart_rx_fifo_ctrl.sv
// RX-side FIFO controller for a 16550-style UART: FCR decode, RX FIFO push/pop, LSR DR/OE, RDA/CTO irqs (UART_RX_TIMEOUT_EN adds the char timeout).
// Latency: push/pop/read data/DR/RDA are combinational; OE, CTO, FIFO enable, trigger level and clear pulses are registered (1 cycle).
// Backpressure: none toward the receiver; a character hitting a full FIFO or occupied holding register is dropped/overwritten and flagged as overrun.
module uart_rx_fifo_ctrl #(
  parameter int BITS_PER_CHAR = 10,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fcr_wr,
  input  logic [7:0] fcr_din,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rbr_rd,
  input  logic       lsr_rd,
  input  logic       bit_tick,
  input  logic [7:0] rxf_dout,
  input  logic       rxf_empty,
  input  logic       rxf_full,
  input  logic       rxf_thre_trigger,
  output logic       rxf_en,
  output logic       rxf_push,
  output logic       rxf_pop,
  output logic [7:0] rxf_din,
  output logic [3:0] rxf_threshold,
  output logic       rxf_clr,
  output logic       txf_clr,
  output logic       fifo_en,
  output logic [7:0] rbr_dout,
  output logic       data_ready,
  output logic       overrun_err,
  output logic       irq_rda,
  output logic       irq_cto
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e     state_q;
  logic       fifo_en_q;
  logic       fifo_en_d;
  logic [3:0] thr_q;
  logic [3:0] thr_d;
  logic       rxf_clr_q;
  logic       txf_clr_q;
  logic       rx_clr_req;
  logic       tx_clr_req;
  logic       in_clear;

  logic       push;
  logic       pop;

  logic [7:0] hold_q;
  logic [7:0] hold_d;
  logic       hold_vld_q;
  logic       hold_vld_d;

  logic       ovr_q;
  logic       ovr_d;
  logic       ovr_set;

  // FCR[5:3] carry DMA mode / reserved bits that this block does not use.
  logic       unused_fcr;
  assign unused_fcr = ^fcr_din[5:3];

  // Decode an FCR write into next enable, trigger level and clear requests.
  // A change of the enable bit flushes both FIFOs, as on the 16550.
  always_comb begin
    fifo_en_d  = fifo_en_q;
    thr_d      = thr_q;
    rx_clr_req = 1'b0;
    tx_clr_req = 1'b0;
    if (fcr_wr) begin
      fifo_en_d = fcr_din[0];
      case (fcr_din[7:6])
        2'b00:   thr_d = 4'd1;
        2'b01:   thr_d = 4'd4;
        2'b10:   thr_d = 4'd8;
        default: thr_d = 4'd14;
      endcase
      rx_clr_req = fcr_din[1] | (fcr_din[0] != fifo_en_q);
      tx_clr_req = fcr_din[2] | (fcr_din[0] != fifo_en_q);
    end
  end

  // Config registers and RUN/CLEAR sequencer; the CLEAR cycle coincides with the rxf_clr pulse.
  // A write landing in CLEAR that again requests an RX clear re-enters CLEAR for one more cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      fifo_en_q <= 1'b0;
      thr_q     <= 4'd1;
      rxf_clr_q <= 1'b0;
      txf_clr_q <= 1'b0;
    end else begin
      fifo_en_q <= fifo_en_d;
      thr_q     <= thr_d;
      rxf_clr_q <= rx_clr_req;
      txf_clr_q <= tx_clr_req;
      case (state_q)
        ST_RUN:   state_q <= rx_clr_req ? ST_CLEAR : ST_RUN;
        ST_CLEAR: state_q <= rx_clr_req ? ST_CLEAR : ST_RUN;
      endcase
    end
  end

  assign in_clear = (state_q == ST_CLEAR);

  // FIFO handshake: blocked entirely while the FIFO is being cleared.
  // A push into a full FIFO is suppressed even when a pop frees a slot this
  // same cycle, since the FIFO's full flag is the only status it gives us.
  assign push = fifo_en_q & ~in_clear & rx_valid & ~rxf_full;
  assign pop  = fifo_en_q & ~in_clear & rbr_rd & ~rxf_empty;

  // Single holding register used when the FIFO is disabled; new data always
  // wins over a simultaneous read so the flag never drops on fresh data.
  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (in_clear || fifo_en_q) begin
      hold_vld_d = 1'b0;
    end else if (rx_valid) begin
      hold_d     = rx_data;
      hold_vld_d = 1'b1;
    end else if (rbr_rd) begin
      hold_vld_d = 1'b0;
    end
  end

  // Overrun: character lost to a full FIFO or an unread holding register.
  // Characters arriving during CLEAR are discarded silently. Set beats clear.
  always_comb begin
    ovr_set = ~in_clear & rx_valid & (fifo_en_q ? rxf_full : hold_vld_q);
    ovr_d   = ovr_q;
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (lsr_rd) begin
      ovr_d = 1'b0;
    end
  end

  // Holding register and overrun flag state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q     <= 8'd0;
      hold_vld_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      ovr_q      <= ovr_d;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int CTO_MAX = TIMEOUT_CHARS * BITS_PER_CHAR;
  localparam int CTO_W   = $clog2(CTO_MAX + 1);
  localparam logic [CTO_W-1:0] CTO_LIMIT = CTO_W'(CTO_MAX);

  logic [CTO_W-1:0] cto_cnt_q;
  logic [CTO_W-1:0] cto_cnt_d;
  logic             cto_q;
  logic             cto_d;
  logic             cto_hit;

  // Idle bit-time counter: runs only while data sits untouched in the FIFO,
  // restarts on any FIFO activity and saturates at the timeout limit.
  always_comb begin
    cto_cnt_d = cto_cnt_q;
    cto_hit   = 1'b0;
    if (in_clear || push || pop || rxf_empty || !fifo_en_q) begin
      cto_cnt_d = '0;
    end else if (bit_tick && (cto_cnt_q != CTO_LIMIT)) begin
      cto_cnt_d = cto_cnt_q + 1'b1;
      cto_hit   = (cto_cnt_d == CTO_LIMIT);
    end
  end

  // Timeout interrupt: CPU read, new data or a clear acknowledge it.
  always_comb begin
    cto_d = cto_q;
    if (in_clear || rbr_rd || push) begin
      cto_d = 1'b0;
    end else if (cto_hit) begin
      cto_d = 1'b1;
    end
  end

  // Timeout counter and interrupt state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cto_cnt_q <= '0;
      cto_q     <= 1'b0;
    end else begin
      cto_cnt_q <= cto_cnt_d;
      cto_q     <= cto_d;
    end
  end

  assign irq_cto = cto_q;
`else
  // Timeout logic not built: the tick input and sizing parameters are unused.
  logic unused_cto;
  assign unused_cto = bit_tick ^ ((TIMEOUT_CHARS * BITS_PER_CHAR) == 0);
  assign irq_cto    = 1'b0;
`endif

  assign rxf_en        = fifo_en_q;
  assign fifo_en       = fifo_en_q;
  assign rxf_threshold = thr_q;
  assign rxf_clr       = rxf_clr_q;
  assign txf_clr       = txf_clr_q;
  assign rxf_push      = push;
  assign rxf_pop       = pop;
  assign rxf_din       = rx_data;
  assign overrun_err   = ovr_q;

  // CPU-facing read data and status muxed by mode.
  assign rbr_dout   = fifo_en_q ? (rxf_empty ? 8'd0 : rxf_dout) : hold_q;
  assign data_ready = fifo_en_q ? ~rxf_empty : hold_vld_q;
  assign irq_rda    = fifo_en_q ? rxf_thre_trigger : hold_vld_q;

endmodule
